mem_dbus_ctrl: RTL and testbench
================================

Name: mem_dbus_ctrl

Overview:
- Data-side bus master for the MEM stage.
- Consumes the MEM stage's access request (ce/we/sel/addr/wdata) and drives an SRAM-like req/addr_ok/data_ok data bus.
- Holds the pipeline with a stall request until the access completes, then returns load data in pipeline lane order.
- Sits between the MEM stage and the data cache/bridge; handles flush of in-flight accesses.

Parameters:
- ADDR_W, 32, width of data address.
- SWAP_LANES, 1, 1 = pipeline lane order (sel[3]/data[31:24] = byte offset 0) is converted to bus little-endian order (wstrb[0]/wdata[7:0] = offset 0); 0 = pass-through.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_ce_i  in  1  MEM stage access valid
- mem_we_i  in  1  store (1) / load (0)
- mem_sel_i  in  4  byte select, pipeline lane order
- mem_addr_i  in  ADDR_W  access address
- mem_data_i  in  32  store data, pipeline lane order
- flush_i  in  1  exception/ertn flush of MEM instruction
- stall_i  in  1  downstream (WB) not accepting this cycle
- stallreq_o  out  1  hold MEM and upstream stages
- rdata_valid_o  out  1  load/store completion for current instruction
- mem_rdata_o  out  32  load data, pipeline lane order
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  0=byte, 1=half, 2=word
- data_wstrb  out  4  bus byte strobes
- data_addr  out  ADDR_W  bus address
- data_wdata  out  32  bus write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response (rdata valid / store done)
- data_rdata  in  32  bus read data

Behaviour:
- Clock/reset: one clock, clk; rst is asynchronous and active-high. On reset: state=IDLE, cancel=0, rdata_q=0. All outputs deassert/zero while rst is high.
- States: IDLE, REQ, WAIT, DONE.
- live = mem_ce_i & !flush_i & !cancel.
- Request issue:
  - data_req = (IDLE & live) | REQ. Issue is combinational, zero added latency.
  - Once data_req is asserted, it and all request fields stay stable until data_addr_ok (flush does not drop it).
- Request fields:
  - data_wr = mem_we_i; data_addr = mem_addr_i.
  - data_wstrb = byte-reversed mem_sel_i when SWAP_LANES, else mem_sel_i. Loads drive the strobe as computed too.
  - data_wdata = byte-reversed mem_data_i (same rule).
  - data_size from popcount(mem_sel_i): 1→0, 2→1, 4→2. Any other sel: size 2 (illegal; mem excp blocks it upstream).
- Transitions:
  - IDLE: data_req & addr_ok & data_ok (same cycle) → DONE if stall_i, else IDLE.
  - IDLE: data_req & addr_ok → WAIT.
  - IDLE: data_req & !addr_ok → REQ.
  - REQ: addr_ok → WAIT (same-cycle data_ok follows the IDLE rule).
  - WAIT: data_ok → DONE if stall_i, else IDLE.
  - DONE: !stall_i | flush_i → IDLE.
- Completion:
  - On the data_ok cycle for a non-cancelled access: rdata_valid_o=1, mem_rdata_o=reversed data_rdata; rdata_q captures it.
  - In DONE: rdata_valid_o=1, mem_rdata_o=rdata_q, no new request issued.
  - Otherwise mem_rdata_o=0.
- stallreq_o = mem_ce_i & !flush_i & !rdata_valid_o, or cancel=1 (new access waits for the orphaned response).
- Flush:
  - Flush in REQ or WAIT sets cancel; the matching data_ok is swallowed (no rdata_valid_o), then cancel clears and state → IDLE.
  - Flush in IDLE with no request: nothing issued.
  - Flush in DONE: → IDLE, rdata_q retained (don't-care).
- Only one outstanding access; a second request never issues before data_ok of the first.
- Stores also wait for data_ok before releasing stall.
- data_ok while IDLE and not cancelled: ignored (bus protocol error; assertion in bench).

Decomposition:
- Shared package (defines file): state encoding constants (IDLE/REQ/WAIT/DONE), size encodings (BYTE=0, HALF=1, WORD=2).
- One natural sub-module: mem_lane_swap (32-bit data + 4-bit strobe byte reversal, SWAP_LANES gated), instantiated for the write path and the read path.

Test Plan:
- ld.w addr 0x1000, addr_ok same cycle, data_ok +2 cycles with rdata 0x44332211 → data_size=2, stallreq_o high 2 cycles, mem_rdata_o=0x11223344 with rdata_valid_o on the data_ok cycle.
- st.b addr 0x1003, sel 4'b0001, data 0xAAAAAAAA, addr_ok delayed 3 cycles → data_req/addr/wstrb=4'b1000/size=0 held stable 4 cycles; stall released on data_ok.
- st.h sel 4'b1100 → wstrb 4'b0011, size 1; zero-wait addr_ok+data_ok same cycle → stallreq_o never asserted.
- ld.b with stall_i=1 at data_ok, held 3 cycles → DONE, mem_rdata_o stable, no second data_req; returns to IDLE when stall_i drops.
- flush_i in WAIT, then new ld from next instruction → orphan data_ok gives no rdata_valid_o; new request issues only after it; new data correct.
- rst asserted mid-WAIT (asynchronous, off-edge) → outputs zero immediately, state IDLE, cancel=0 after release.

Source files
------------

// File: rtl/mem_dbus_ctrl_pkg.sv
// Shared definitions for the MEM-stage data bus master: FSM states,
// bus size encodings and the byte-select to size helper.
package mem_dbus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Access size from the number of selected bytes; odd patterns fall back
  // to a word, they never reach the bus because the MEM stage traps them.
  function automatic logic [1:0] size_from_sel(input logic [3:0] sel);
    logic [2:0] cnt;
    cnt = {2'b00, sel[0]} + {2'b00, sel[1]} + {2'b00, sel[2]} + {2'b00, sel[3]};
    case (cnt)
      3'd1:    return SIZE_BYTE;
      3'd2:    return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_swap.sv
// Byte-lane reversal between pipeline lane order (byte offset 0 in the top
// byte) and bus little-endian order. Pass-through when swapping is disabled.
module mem_lane_swap #(
  parameter int SWAP_LANES = 1
) (
  input  logic [31:0] data_in,
  input  logic [3:0]  strb_in,
  output logic [31:0] data_out,
  output logic [3:0]  strb_out
);

  // Reverse bytes of data and bits of the per-byte strobe together.
  always_comb begin
    if (SWAP_LANES != 0) begin
      data_out = {data_in[7:0], data_in[15:8], data_in[23:16], data_in[31:24]};
      strb_out = {strb_in[0], strb_in[1], strb_in[2], strb_in[3]};
    end else begin
      data_out = data_in;
      strb_out = strb_in;
    end
  end

endmodule

// File: rtl/mem_dbus_ctrl.sv
// Data-side bus master for the MEM stage. Issues one SRAM-like access at a
// time, stalls the pipeline until it completes and returns load data in
// pipeline lane order. A flush while an access is in flight leaves the
// response orphaned; it is swallowed before any new access is issued.
module mem_dbus_ctrl
  import mem_dbus_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int SWAP_LANES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_data_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              stallreq_o,
  output logic              rdata_valid_o,
  output logic [31:0]       mem_rdata_o,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
);

  state_t      state;
  state_t      state_next;
  logic        cancel;
  logic        cancel_next;
  logic [31:0] rdata_q;

  logic        live;
  logic        req;
  logic        addr_fire;
  logic        resp;
  logic        resp_ok;
  logic        valid;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] rd_data;
  logic [3:0]  rd_strb_unused;

  mem_lane_swap #(.SWAP_LANES(SWAP_LANES)) u_wr_swap (
    .data_in  (mem_data_i),
    .strb_in  (mem_sel_i),
    .data_out (wr_data),
    .strb_out (wr_strb)
  );

  mem_lane_swap #(.SWAP_LANES(SWAP_LANES)) u_rd_swap (
    .data_in  (data_rdata),
    .strb_in  (4'b0000),
    .data_out (rd_data),
    .strb_out (rd_strb_unused)
  );

  // Handshake decode: request, acceptance, response and whether it counts.
  always_comb begin
    live      = mem_ce_i & ~flush_i & ~cancel;
    req       = ((state == ST_IDLE) & live) | (state == ST_REQ);
    addr_fire = req & data_addr_ok;
    resp      = ((state == ST_WAIT) | addr_fire) & data_data_ok;
    // A response reports completion only if its instruction is still alive.
    resp_ok   = resp & ~cancel & ~flush_i;
    valid     = resp_ok | (state == ST_DONE);
  end

  // Next state and orphan-response tracking.
  always_comb begin
    state_next  = state;
    cancel_next = cancel;
    case (state)
      ST_IDLE: begin
        if (resp) begin
          state_next = (resp_ok & stall_i) ? ST_DONE : ST_IDLE;
        end else if (addr_fire) begin
          state_next = ST_WAIT;
        end else if (req) begin
          state_next = ST_REQ;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (resp) begin
          state_next = (resp_ok & stall_i) ? ST_DONE : ST_IDLE;
        end else if (data_addr_ok) begin
          state_next = ST_WAIT;
        end else begin
          state_next = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (resp) begin
          state_next = (resp_ok & stall_i) ? ST_DONE : ST_IDLE;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (~stall_i | flush_i) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // The outstanding response always retires the cancel; a flush while an
    // access is in flight marks its response as orphaned.
    if (resp) begin
      cancel_next = 1'b0;
    end else if (flush_i & ((state == ST_REQ) | (state == ST_WAIT))) begin
      cancel_next = 1'b1;
    end else begin
      cancel_next = cancel;
    end
  end

  // State, cancel flag and held load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cancel  <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      state  <= state_next;
      cancel <= cancel_next;
      if (resp_ok) begin
        rdata_q <= rd_data;
      end
    end
  end

  // Output drive; everything is forced quiet while reset is asserted.
  always_comb begin
    stallreq_o    = 1'b0;
    rdata_valid_o = 1'b0;
    mem_rdata_o   = 32'h0000_0000;
    data_req      = 1'b0;
    data_wr       = 1'b0;
    data_size     = SIZE_BYTE;
    data_wstrb    = 4'b0000;
    data_addr     = '0;
    data_wdata    = 32'h0000_0000;
    if (!rst) begin
      stallreq_o    = (mem_ce_i & ~flush_i & ~valid) | cancel;
      rdata_valid_o = valid;
      if (resp_ok) begin
        mem_rdata_o = rd_data;
      end else if (state == ST_DONE) begin
        mem_rdata_o = rdata_q;
      end else begin
        mem_rdata_o = 32'h0000_0000;
      end
      data_req   = req;
      data_wr    = mem_we_i;
      data_size  = size_from_sel(mem_sel_i);
      data_wstrb = wr_strb;
      data_addr  = mem_addr_i;
      data_wdata = wr_data;
    end
  end

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed bench for mem_dbus_ctrl: inputs change 1 time unit after the
// rising edge, outputs are checked mid-cycle; load/store results come from a
// scoreboard queue filled when each access is driven.
module tb_mem_dbus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce_i, mem_we_i, flush_i, stall_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i, mem_data_i;
  logic        stallreq_o, rdata_valid_o;
  logic [31:0] mem_rdata_o;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_dbus_ctrl #(.ADDR_W(32), .SWAP_LANES(1)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .flush_i(flush_i), .stall_i(stall_i),
    .stallreq_o(stallreq_o), .rdata_valid_o(rdata_valid_o), .mem_rdata_o(mem_rdata_o),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  function automatic logic [31:0] rev32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Completion point: valid must be high and data must match the scoreboard.
  task automatic complete(input string tag);
    logic [31:0] e;
    chk({tag, "_valid"}, {31'd0, rdata_valid_o}, 32'd1);
    n_assert++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, mem_rdata_o, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    #2;
  endtask

  task automatic access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] wdat);
    mem_ce_i = 1'b1; mem_we_i = we; mem_sel_i = sel; mem_addr_i = addr; mem_data_i = wdat;
  endtask

  initial begin
    rst = 1'b1; mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF;
    mem_addr_i = 32'h0; mem_data_i = 32'h0; flush_i = 1'b0; stall_i = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;

    // Reset: outputs quiet even with a live request at the input.
    mid;
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
    chk("rst_valid", {31'd0, rdata_valid_o}, 32'd0);
    tick; tick;
    rst = 1'b0; mem_ce_i = 1'b0;
    mid;
    chk("idle_req", {31'd0, data_req}, 32'd0);
    tick;

    // ld.w, addr_ok at issue, data_ok two cycles later.
    access(1'b0, 4'hF, 32'h1000, 32'h0); data_addr_ok = 1'b1;
    exp_q.push_back(rev32(32'h44332211));
    mid;
    chk("ldw_req", {31'd0, data_req}, 32'd1);
    chk("ldw_size", {30'd0, data_size}, 32'd2);
    chk("ldw_addr", data_addr, 32'h1000);
    chk("ldw_stall0", {31'd0, stallreq_o}, 32'd1);
    tick;
    data_addr_ok = 1'b0;
    mid;
    chk("ldw_stall1", {31'd0, stallreq_o}, 32'd1);
    chk("ldw_noreq", {31'd0, data_req}, 32'd0);
    tick;
    data_data_ok = 1'b1; data_rdata = 32'h44332211;
    mid;
    complete("ldw");
    chk("ldw_release", {31'd0, stallreq_o}, 32'd0);
    tick;
    data_data_ok = 1'b0; mem_ce_i = 1'b0;
    mid;
    chk("ldw_idle_rdata", mem_rdata_o, 32'h0);
    tick;

    // st.b with addr_ok delayed three cycles: request must hold steady.
    access(1'b1, 4'b0001, 32'h1003, 32'hAAAAAAAA);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      data_addr_ok = (i == 3);
      mid;
      chk("stb_req", {31'd0, data_req}, 32'd1);
      chk("stb_wr", {31'd0, data_wr}, 32'd1);
      chk("stb_addr", data_addr, 32'h1003);
      chk("stb_wstrb", {28'd0, data_wstrb}, 32'h8);
      chk("stb_size", {30'd0, data_size}, 32'd0);
      chk("stb_stall", {31'd0, stallreq_o}, 32'd1);
      tick;
    end
    data_addr_ok = 1'b0;
    mid;
    chk("stb_wait_stall", {31'd0, stallreq_o}, 32'd1);
    tick;
    data_data_ok = 1'b1; data_rdata = 32'h0;
    mid;
    complete("stb");
    chk("stb_release", {31'd0, stallreq_o}, 32'd0);
    tick;
    data_data_ok = 1'b0; mem_ce_i = 1'b0;
    tick;

    // st.h, zero-wait: stall never raised.
    access(1'b1, 4'b1100, 32'h2000, 32'h12345678);
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0;
    exp_q.push_back(32'h0);
    mid;
    chk("sth_stall", {31'd0, stallreq_o}, 32'd0);
    chk("sth_wstrb", {28'd0, data_wstrb}, 32'h3);
    chk("sth_size", {30'd0, data_size}, 32'd1);
    chk("sth_wdata", data_wdata, 32'h78563412);
    complete("sth");
    tick;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; mem_ce_i = 1'b0;
    mid;
    chk("sth_idle", {31'd0, data_req}, 32'd0);
    tick;

    // ld.b completing under a WB stall: hold in DONE.
    access(1'b0, 4'b1000, 32'h3000, 32'h0); data_addr_ok = 1'b1;
    exp_q.push_back(rev32(32'h000000AB));
    mid;
    chk("ldb_wstrb", {28'd0, data_wstrb}, 32'h1);
    chk("ldb_size", {30'd0, data_size}, 32'd0);
    tick;
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h000000AB; stall_i = 1'b1;
    mid;
    complete("ldb");
    tick;
    data_data_ok = 1'b0; data_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      mid;
      chk("ldb_done_valid", {31'd0, rdata_valid_o}, 32'd1);
      chk("ldb_done_rdata", mem_rdata_o, 32'hAB000000);
      chk("ldb_done_noreq", {31'd0, data_req}, 32'd0);
      tick;
    end
    stall_i = 1'b0;
    mid;
    chk("ldb_done_last", mem_rdata_o, 32'hAB000000);
    tick;
    mem_ce_i = 1'b0;
    mid;
    chk("ldb_back_idle", {31'd0, rdata_valid_o}, 32'd0);
    tick;

    // Flush in WAIT, then a new load waits for the orphaned response.
    access(1'b0, 4'hF, 32'h4000, 32'h0); data_addr_ok = 1'b1;
    tick;
    data_addr_ok = 1'b0; flush_i = 1'b1;
    mid;
    chk("fl_valid", {31'd0, rdata_valid_o}, 32'd0);
    tick;
    flush_i = 1'b0;
    access(1'b0, 4'hF, 32'h5000, 32'h0);
    for (int i = 0; i < 2; i++) begin
      mid;
      chk("fl_blocked_req", {31'd0, data_req}, 32'd0);
      chk("fl_blocked_stall", {31'd0, stallreq_o}, 32'd1);
      tick;
    end
    data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
    mid;
    chk("fl_orphan_valid", {31'd0, rdata_valid_o}, 32'd0);
    chk("fl_orphan_req", {31'd0, data_req}, 32'd0);
    chk("fl_orphan_stall", {31'd0, stallreq_o}, 32'd1);
    tick;
    data_data_ok = 1'b0; data_addr_ok = 1'b1;
    exp_q.push_back(rev32(32'h01020304));
    mid;
    chk("fl_new_req", {31'd0, data_req}, 32'd1);
    chk("fl_new_addr", data_addr, 32'h5000);
    tick;
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h01020304;
    mid;
    complete("fl_new");
    tick;
    data_data_ok = 1'b0; mem_ce_i = 1'b0;
    tick;

    // Asynchronous reset in the middle of WAIT.
    access(1'b0, 4'hF, 32'h6000, 32'h0); data_addr_ok = 1'b1;
    tick;
    data_addr_ok = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_stall", {31'd0, stallreq_o}, 32'd0);
    chk("arst_req", {31'd0, data_req}, 32'd0);
    chk("arst_addr", data_addr, 32'h0);
    chk("arst_rdata", mem_rdata_o, 32'h0);
    tick;
    #3 rst = 1'b0;
    #1;
    chk("arst_reissue", {31'd0, data_req}, 32'd1);
    chk("arst_stall_after", {31'd0, stallreq_o}, 32'd1);
    tick;
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
    exp_q.push_back(rev32(32'hCAFEF00D));
    mid;
    complete("arst_ld");
    tick;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; mem_ce_i = 1'b0;
    mid;
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
